// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the FFT control and datapath blocks.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WB, FIN} fft_state_t;

  function automatic int fft_log2n(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  localparam int FFT_SAMPLES = 4;
  localparam int FFT_IDX_W   = fft_log2n(FFT_SAMPLES);
  localparam int FFT_TW_W    = FFT_IDX_W - 1;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Butterfly command channel: operand index pair plus twiddle exponent, valid/ready.
interface fft_stage_sequencer_if #(
  parameter int SAMPLES = 4
);
  localparam int IW = fft_pkg::fft_log2n(SAMPLES);

  logic          bf_valid;
  logic          bf_ready;
  logic [IW-1:0] in1_idx;
  logic [IW-1:0] in2_idx;
  logic [IW-2:0] twiddle_idx;

  modport master (output bf_valid, in1_idx, in2_idx, twiddle_idx, input bf_ready);
  modport slave  (input bf_valid, in1_idx, in2_idx, twiddle_idx, output bf_ready);
endinterface

// File: rtl/fft_addr_gen.sv
// Combinational (stage, group, butterfly) to operand/twiddle index mapping.
module fft_addr_gen import fft_pkg::*; #(
  parameter int SAMPLES = 4
) (
  input  logic [fft_log2n(SAMPLES)-1:0] s,
  input  logic [fft_log2n(SAMPLES)-1:0] g,
  input  logic [fft_log2n(SAMPLES)-1:0] j,
  output logic [fft_log2n(SAMPLES)-1:0] in1,
  output logic [fft_log2n(SAMPLES)-1:0] in2,
  output logic [fft_log2n(SAMPLES)-2:0] tw
);
  localparam int IW = fft_log2n(SAMPLES);
  localparam int TW = IW - 1;

  logic [IW-1:0] half;
  logic [IW-1:0] base;

  // base = g * 2 * half; all terms stay below N so index-width arithmetic is exact
  always_comb begin
    half = IW'(1) << s;
    base = (g << s) << 1;
    in1  = base + j;
    in2  = in1 + half;
    tw   = TW'(j << (IW'(IW - 1) - s));
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Walks every stage/group/butterfly of a radix-2 DIT FFT over one shared butterfly unit.
module fft_stage_sequencer import fft_pkg::*; #(
  parameter int SAMPLES = 4,
  parameter int WB_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  fft_stage_sequencer_if.master         bf,
  output logic [fft_log2n(SAMPLES)-1:0] stage,
  output logic                          busy,
  output logic                          done
);
  localparam int IW  = fft_log2n(SAMPLES);
  localparam int TW  = IW - 1;
  localparam int WBW = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;

  fft_state_t    state, state_n;
  logic [IW-1:0] s, g, j;
  logic [IW-1:0] s_n, g_n, j_n;
  logic [WBW-1:0] wb_cnt, wb_n;
  logic [IW-1:0] half_m1, grp_m1;
  logic [IW-1:0] in1_n, in2_n;
  logic [TW-1:0] tw_n;

  always_comb begin
    half_m1 = (IW'(1) << s) - IW'(1);
    grp_m1  = IW'((SAMPLES >> (int'(s) + 1)) - 1);
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    g_n     = g;
    j_n     = j;
    wb_n    = wb_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          s_n     = '0;
          g_n     = '0;
          j_n     = '0;
        end
      end
      ISSUE: begin
        if (bf.bf_valid && bf.bf_ready) begin
          if (j == half_m1) begin
            j_n = '0;
            if (g == grp_m1) begin
              g_n     = '0;
              wb_n    = '0;
              state_n = WB;
            end else begin
              g_n = g + IW'(1);
            end
          end else begin
            j_n = j + IW'(1);
          end
        end
      end
      WB: begin
        if (wb_cnt == WBW'(WB_LAT - 1)) begin
          if (s == IW'(IW - 1)) begin
            state_n = FIN;
          end else begin
            s_n     = s + IW'(1);
            state_n = ISSUE;
          end
        end else begin
          wb_n = wb_cnt + WBW'(1);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  fft_addr_gen #(.SAMPLES(SAMPLES)) u_addr_gen (
    .s   (s_n),
    .g   (g_n),
    .j   (j_n),
    .in1 (in1_n),
    .in2 (in2_n),
    .tw  (tw_n)
  );

  // Outputs are registered from the next-state counters so a command lands the cycle its state begins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      s              <= '0;
      g              <= '0;
      j              <= '0;
      wb_cnt         <= '0;
      bf.bf_valid    <= 1'b0;
      bf.in1_idx     <= '0;
      bf.in2_idx     <= '0;
      bf.twiddle_idx <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      s              <= s_n;
      g              <= g_n;
      j              <= j_n;
      wb_cnt         <= wb_n;
      bf.bf_valid    <= (state_n == ISSUE);
      bf.in1_idx     <= in1_n;
      bf.in2_idx     <= in2_n;
      bf.twiddle_idx <= tw_n;
      busy           <= (state_n != IDLE);
      done           <= (state_n == FIN);
    end
  end

  assign stage = s;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: three configurations checked against a loop-order reference model.
module tb_fft_stage_sequencer;

  typedef struct {
    int cyc;
    int in1;
    int in2;
    int tw;
    int st;
  } bf_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;
  logic ready4  = 1'b0;
  logic ready8  = 1'b0;
  logic ready16 = 1'b0;

  logic [1:0] stage4;
  logic [2:0] stage8;
  logic [3:0] stage16;
  logic busy4, busy8, busy16;
  logic done4, done8, done16;

  int cyc    = 0;
  int checks = 0;
  int fails  = 0;

  bf_t log4[$];
  bf_t log8[$];
  bf_t log16[$];
  bf_t exp_q[$];
  int  dq4[$];
  int  dq8[$];
  int  dq16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage_sequencer_if #(.SAMPLES(4))  bf4 ();
  fft_stage_sequencer_if #(.SAMPLES(8))  bf8 ();
  fft_stage_sequencer_if #(.SAMPLES(16)) bf16 ();

  assign bf4.bf_ready  = ready4;
  assign bf8.bf_ready  = ready8;
  assign bf16.bf_ready = ready16;

  fft_stage_sequencer #(.SAMPLES(4), .WB_LAT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bf(bf4),
    .stage(stage4), .busy(busy4), .done(done4)
  );
  fft_stage_sequencer #(.SAMPLES(8), .WB_LAT(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .bf(bf8),
    .stage(stage8), .busy(busy8), .done(done8)
  );
  fft_stage_sequencer #(.SAMPLES(16), .WB_LAT(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .bf(bf16),
    .stage(stage16), .busy(busy16), .done(done16)
  );

  // Handshakes and done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (bf4.bf_valid === 1'b1 && ready4 === 1'b1)
      log4.push_back('{cyc, int'(bf4.in1_idx), int'(bf4.in2_idx), int'(bf4.twiddle_idx), int'(stage4)});
    if (bf8.bf_valid === 1'b1 && ready8 === 1'b1)
      log8.push_back('{cyc, int'(bf8.in1_idx), int'(bf8.in2_idx), int'(bf8.twiddle_idx), int'(stage8)});
    if (bf16.bf_valid === 1'b1 && ready16 === 1'b1)
      log16.push_back('{cyc, int'(bf16.in1_idx), int'(bf16.in2_idx), int'(bf16.twiddle_idx), int'(stage16)});
    if (done4 === 1'b1)  dq4.push_back(cyc);
    if (done8 === 1'b1)  dq8.push_back(cyc);
    if (done16 === 1'b1) dq16.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    ready4  = 1'b1;
    ready8  = 1'b1;
    ready16 = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference: plain nested loops over stage, group, butterfly; appends to exp_q.
  // cyc is the expected handshake cycle with ready always high and start sampled at edge t0.
  function automatic void build_model(int n, int wb, int t0);
    int lg = 0;
    while ((1 << lg) < n) lg++;
    for (int s = 0; s < lg; s++) begin
      int half = 1 << s;
      for (int g = 0; g < n / (2 * half); g++) begin
        for (int j = 0; j < half; j++) begin
          bf_t e;
          e.in1 = g * 2 * half + j;
          e.in2 = e.in1 + half;
          e.tw  = j * (n / (2 * half));
          e.st  = s;
          e.cyc = t0 + 1 + s * (n / 2 + wb) + g * half + j;
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (bf4.bf_valid !== 1'b0) begin fails++; $display("FAIL reset_valid4 got %b expected 0", bf4.bf_valid); end
    checks++; if (bf4.in1_idx !== 2'd0) begin fails++; $display("FAIL reset_in1 got %0d expected 0", bf4.in1_idx); end
    checks++; if (bf4.in2_idx !== 2'd0) begin fails++; $display("FAIL reset_in2 got %0d expected 0", bf4.in2_idx); end
    checks++; if (bf4.twiddle_idx !== 1'd0) begin fails++; $display("FAIL reset_tw got %0d expected 0", bf4.twiddle_idx); end
    checks++; if (stage4 !== 2'd0) begin fails++; $display("FAIL reset_stage got %0d expected 0", stage4); end
    checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy4); end
    checks++; if (done4 !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", done4); end
    checks++; if (bf8.bf_valid !== 1'b0 || busy8 !== 1'b0 || stage8 !== 3'd0) begin
      fails++; $display("FAIL reset_dut8 got valid=%b busy=%b stage=%0d expected 0/0/0", bf8.bf_valid, busy8, stage8);
    end
    checks++; if (bf16.bf_valid !== 1'b0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
      fails++; $display("FAIL reset_dut16 got valid=%b busy=%b done=%b expected 0/0/0", bf16.bf_valid, busy16, done16);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_n4_basic();
    int t0, b, d;
    do_reset();
    b = log4.size();
    d = dq4.size();
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      int es;
      @(negedge clk);
      checks++;
      if (busy4 !== (k <= 7)) begin fails++; $display("FAIL n4_busy cycle %0d got %b expected %0d", k, busy4, (k <= 7)); end
      if (k <= 7) begin
        es = (k - 1) / 3;
        if (es > 1) es = 1;
        checks++;
        if (int'(stage4) !== es) begin fails++; $display("FAIL n4_stage cycle %0d got %0d expected %0d", k, stage4, es); end
      end
    end
    exp_q.delete();
    build_model(4, 1, t0);
    checks++;
    if (log4.size() - b !== exp_q.size()) begin fails++; $display("FAIL n4_count got %0d expected %0d", log4.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < log4.size(); i++) begin
      bf_t a;
      a = log4[b + i];
      checks++;
      if (a.in1 !== exp_q[i].in1 || a.in2 !== exp_q[i].in2 || a.tw !== exp_q[i].tw || a.st !== exp_q[i].st || a.cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL n4_bf[%0d] got (%0d,%0d,tw%0d,s%0d)@%0d expected (%0d,%0d,tw%0d,s%0d)@%0d", i,
                 a.in1, a.in2, a.tw, a.st, a.cyc, exp_q[i].in1, exp_q[i].in2, exp_q[i].tw, exp_q[i].st, exp_q[i].cyc);
      end
    end
    checks++;
    if (dq4.size() - d !== 1) begin fails++; $display("FAIL n4_done_count got %0d expected 1", dq4.size() - d); end
    else begin
      checks++;
      if (dq4[d] !== t0 + 2 * (2 + 1) + 1) begin fails++; $display("FAIL n4_done_time got %0d expected %0d", dq4[d] - t0, 7); end
    end
  endtask

  task automatic test_n8_wb2();
    int t0, b, d;
    do_reset();
    b = log8.size();
    d = dq8.size();
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (24) tick();
    exp_q.delete();
    build_model(8, 2, t0);
    checks++;
    if (log8.size() - b !== exp_q.size()) begin fails++; $display("FAIL n8_count got %0d expected %0d", log8.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < log8.size(); i++) begin
      bf_t a;
      a = log8[b + i];
      checks++;
      if (a.in1 !== exp_q[i].in1 || a.in2 !== exp_q[i].in2 || a.tw !== exp_q[i].tw || a.st !== exp_q[i].st || a.cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL n8_bf[%0d] got (%0d,%0d,tw%0d,s%0d)@%0d expected (%0d,%0d,tw%0d,s%0d)@%0d", i,
                 a.in1, a.in2, a.tw, a.st, a.cyc, exp_q[i].in1, exp_q[i].in2, exp_q[i].tw, exp_q[i].st, exp_q[i].cyc);
      end
    end
    checks++;
    if (dq8.size() - d !== 1) begin fails++; $display("FAIL n8_done_count got %0d expected 1", dq8.size() - d); end
    else begin
      checks++;
      if (dq8[d] - t0 !== 3 * (4 + 2) + 1) begin fails++; $display("FAIL n8_done_time got %0d expected %0d", dq8[d] - t0, 3 * (4 + 2) + 1); end
    end
  endtask

  task automatic test_stall();
    int t0, b, d;
    do_reset();
    b = log4.size();
    d = dq4.size();
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ready4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bf4.bf_valid !== 1'b1 || bf4.in1_idx !== 2'd2 || bf4.in2_idx !== 2'd3 || bf4.twiddle_idx !== 1'd0) begin
        fails++;
        $display("FAIL stall_hold[%0d] got v=%b (%0d,%0d,tw%0d) expected v=1 (2,3,tw0)", k, bf4.bf_valid, bf4.in1_idx, bf4.in2_idx, bf4.twiddle_idx);
      end
      tick();
    end
    ready4 = 1'b1;
    repeat (10) tick();
    exp_q.delete();
    build_model(4, 1, t0);
    checks++;
    if (log4.size() - b !== exp_q.size()) begin fails++; $display("FAIL stall_count got %0d expected %0d", log4.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < log4.size(); i++) begin
      bf_t a;
      int ec;
      a = log4[b + i];
      ec = exp_q[i].cyc + ((i >= 1) ? 3 : 0);
      checks++;
      if (a.in1 !== exp_q[i].in1 || a.in2 !== exp_q[i].in2 || a.tw !== exp_q[i].tw || a.cyc !== ec) begin
        fails++;
        $display("FAIL stall_bf[%0d] got (%0d,%0d,tw%0d)@%0d expected (%0d,%0d,tw%0d)@%0d", i,
                 a.in1, a.in2, a.tw, a.cyc, exp_q[i].in1, exp_q[i].in2, exp_q[i].tw, ec);
      end
    end
    checks++;
    if (dq4.size() - d !== 1) begin fails++; $display("FAIL stall_done_count got %0d expected 1", dq4.size() - d); end
    else begin
      checks++;
      if (dq4[d] - t0 !== 7 + 3) begin fails++; $display("FAIL stall_done_time got %0d expected %0d", dq4[d] - t0, 10); end
    end
  endtask

  task automatic test_start_ignored();
    int t0, b, d;
    do_reset();
    b = log4.size();
    d = dq4.size();
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    exp_q.delete();
    build_model(4, 1, t0);
    checks++;
    if (log4.size() - b !== exp_q.size()) begin fails++; $display("FAIL ign_count got %0d expected %0d", log4.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < log4.size(); i++) begin
      bf_t a;
      a = log4[b + i];
      checks++;
      if (a.in1 !== exp_q[i].in1 || a.in2 !== exp_q[i].in2 || a.tw !== exp_q[i].tw || a.cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL ign_bf[%0d] got (%0d,%0d,tw%0d)@%0d expected (%0d,%0d,tw%0d)@%0d", i,
                 a.in1, a.in2, a.tw, a.cyc, exp_q[i].in1, exp_q[i].in2, exp_q[i].tw, exp_q[i].cyc);
      end
    end
    checks++;
    if (dq4.size() - d !== 1) begin fails++; $display("FAIL ign_done_count got %0d expected 1", dq4.size() - d); end
  endtask

  task automatic test_start_held();
    int t0, b, d;
    do_reset();
    b = log4.size();
    d = dq4.size();
    t0 = cyc;
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    repeat (12) tick();
    exp_q.delete();
    build_model(4, 1, t0);
    build_model(4, 1, t0 + 8);
    checks++;
    if (log4.size() - b !== exp_q.size()) begin fails++; $display("FAIL held_count got %0d expected %0d", log4.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < log4.size(); i++) begin
      bf_t a;
      a = log4[b + i];
      checks++;
      if (a.in1 !== exp_q[i].in1 || a.in2 !== exp_q[i].in2 || a.tw !== exp_q[i].tw || a.cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL held_bf[%0d] got (%0d,%0d,tw%0d)@%0d expected (%0d,%0d,tw%0d)@%0d", i,
                 a.in1, a.in2, a.tw, a.cyc, exp_q[i].in1, exp_q[i].in2, exp_q[i].tw, exp_q[i].cyc);
      end
    end
    checks++;
    if (dq4.size() - d !== 2) begin fails++; $display("FAIL held_done_count got %0d expected 2", dq4.size() - d); end
    else begin
      checks++;
      if (dq4[d] - t0 !== 7 || dq4[d + 1] - t0 !== 15) begin
        fails++; $display("FAIL held_done_time got %0d,%0d expected 7,15", dq4[d] - t0, dq4[d + 1] - t0);
      end
    end
  endtask

  task automatic test_mid_reset();
    int t0, t1, b, d;
    do_reset();
    d = dq4.size();
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bf4.bf_valid !== 1'b0 || stage4 !== 2'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      fails++; $display("FAIL midrst_state got v=%b s=%0d busy=%b done=%b expected 0/0/0/0", bf4.bf_valid, stage4, busy4, done4);
    end
    b = log4.size();
    #1;
    t1 = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) tick();
    checks++;
    if (dq4.size() - d !== 1) begin fails++; $display("FAIL midrst_done_count got %0d expected 1 (t0=%0d)", dq4.size() - d, t0); end
    exp_q.delete();
    build_model(4, 1, t1);
    checks++;
    if (log4.size() - b !== exp_q.size()) begin fails++; $display("FAIL midrst_count got %0d expected %0d", log4.size() - b, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && b + i < log4.size(); i++) begin
      bf_t a;
      a = log4[b + i];
      checks++;
      if (a.in1 !== exp_q[i].in1 || a.in2 !== exp_q[i].in2 || a.tw !== exp_q[i].tw || a.cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL midrst_bf[%0d] got (%0d,%0d,tw%0d)@%0d expected (%0d,%0d,tw%0d)@%0d", i,
                 a.in1, a.in2, a.tw, a.cyc, exp_q[i].in1, exp_q[i].in2, exp_q[i].tw, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_random_n16();
    int b, d, n;
    bit seen;
    do_reset();
    b = log16.size();
    d = dq16.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 2000) begin
      ready16 = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (dq16.size() > d) seen = 1'b1;
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL rnd_timeout got no done in %0d cycles expected done", n); end
    ready16 = 1'b1;
    repeat (10) tick();
    exp_q.delete();
    build_model(16, 1, 0);
    checks++;
    if (log16.size() - b !== 32) begin fails++; $display("FAIL rnd_count got %0d expected 32", log16.size() - b); end
    for (int i = 0; i < exp_q.size() && b + i < log16.size(); i++) begin
      bf_t a;
      a = log16[b + i];
      checks++;
      if (a.in1 !== exp_q[i].in1 || a.in2 !== exp_q[i].in2 || a.tw !== exp_q[i].tw || a.st !== exp_q[i].st) begin
        fails++;
        $display("FAIL rnd_bf[%0d] got (%0d,%0d,tw%0d,s%0d) expected (%0d,%0d,tw%0d,s%0d)", i,
                 a.in1, a.in2, a.tw, a.st, exp_q[i].in1, exp_q[i].in2, exp_q[i].tw, exp_q[i].st);
      end
    end
    checks++;
    if (dq16.size() - d !== 1) begin fails++; $display("FAIL rnd_done_count got %0d expected 1", dq16.size() - d); end
  endtask

  initial begin
    test_reset();
    test_n4_basic();
    test_n8_wb2();
    test_stall();
    test_start_ignored();
    test_start_held();
    test_mid_reset();
    test_random_n16();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
